// File: rtl/icache_refill_axi.sv
// icache_refill_axi: AXI4 read-burst line-fill engine for the instruction cache.
// Takes one miss address, issues a single LINE_WORDS-beat read burst, assembles
// the beats into a line and returns it with a valid/ready handshake.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_addr     miss request from the icache controller
//   resp_valid/resp_ready            assembled line handshake
//   resp_line, resp_err              line data (word i at [i*DATA_WIDTH +: DATA_WIDTH]), fill error
//   arvalid/arready/araddr/arid/arlen/arsize/arburst   AXI read address channel
//   rvalid/rready/rdata/rresp/rid/rlast                AXI read data channel
//
// Optional feature: define ICACHE_REFILL_WRAP_EN for critical-word-first refill
// (WRAP burst starting at the missing word). Default build uses INCR from line base.
module icache_refill_axi #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LINE_WORDS   = 8,
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned FILL_ID      = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_line,
  output logic                             resp_err,
  output logic                             arvalid,
  input  logic                             arready,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic [AXI_ID_WIDTH-1:0]          arid,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  input  logic                             rvalid,
  output logic                             rready,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic [AXI_ID_WIDTH-1:0]          rid,
  input  logic                             rlast
);

  localparam int unsigned BEAT_BYTES_LOG = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LINE_BYTES_LOG = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int unsigned CNT_W          = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W         = LINE_WORDS * DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

`ifdef ICACHE_REFILL_WRAP_EN
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'((1 << BEAT_BYTES_LOG) - 1);
`else
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << LINE_BYTES_LOG) - 1);
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      start_q, start_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, arvalid_q, rready_q, resp_valid_q;

  logic [CNT_W-1:0]      widx;
  logic                  beat;
  logic                  last_beat;
  logic                  unused_sig;

  // Destination word wraps inside the line using only the counter-width bits.
  assign widx      = start_q + cnt_q;
  assign beat      = rvalid & rready_q;
  assign last_beat = (cnt_q == LAST_CNT);
  assign unused_sig = ^{rid, rresp[0]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      start_q      <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      line_q       <= line_d;
      err_q        <= err_d;
      req_ready_q  <= (state_d == IDLE);
      arvalid_q    <= (state_d == ADDR);
      rready_q     <= (state_d == DATA);
      resp_valid_q <= (state_d == DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ADDR;
`ifdef ICACHE_REFILL_WRAP_EN
          addr_d  = req_addr & BEAT_MASK;
          start_d = req_addr[LINE_BYTES_LOG-1:BEAT_BYTES_LOG];
`else
          addr_d  = req_addr & LINE_MASK;
          start_d = '0;
`endif
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (beat) begin
          for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (widx == CNT_W'(i)) line_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
          end
          // Sticky error: slave error or rlast disagreeing with the beat count.
          err_d = err_q | rresp[1] | (rlast != last_beat);
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign resp_valid = resp_valid_q;
  assign resp_line  = line_q;
  assign resp_err   = err_q;
  assign araddr     = addr_q;
  assign arid       = AXI_ID_WIDTH'(FILL_ID);
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'(BEAT_BYTES_LOG);
`ifdef ICACHE_REFILL_WRAP_EN
  assign arburst    = 2'b10;
`else
  assign arburst    = 2'b01;
`endif

endmodule

// File: tb/tb_icache_refill_axi.sv
// Self-checking bench for icache_refill_axi (default geometry: 8 x 32-bit words).
// A behavioural AXI slave drives the bursts; expected lines and error flags come
// from a line-level model (beat k lands at word (start+k) mod 8).
module tb_icache_refill_axi;

`ifdef ICACHE_REFILL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_line;
  logic         resp_err;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [3:0]   rid;
  logic         rlast;

  icache_refill_axi dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Observations captured by the slave driver.
  logic [255:0] obs_line;
  logic         obs_err;
  logic [31:0]  obs_araddr;
  logic [1:0]   obs_arburst;
  logic [7:0]   obs_arlen;
  logic [2:0]   obs_arsize;
  logic [3:0]   obs_arid;
  int           obs_ar_cycle, obs_resp_cycle, obs_beats_at_resp;
  bit           obs_ar_unstable, obs_rready_early, obs_busy_bad, obs_hold_bad, obs_timeout;
  logic         obs_req_ready_after;

  function automatic logic [255:0] model_line(input logic [31:0] addr, input logic [31:0] beats [8]);
    logic [255:0] l;
    int s;
    l = '0;
    s = WRAP_EN ? int'((addr / 4) % 8) : 0;
    for (int k = 0; k < 8; k++) l[((s + k) % 8) * 32 +: 32] = beats[k];
    return l;
  endfunction

  function automatic logic [31:0] model_araddr(input logic [31:0] addr);
    return WRAP_EN ? (addr & ~32'h3) : (addr & ~32'h1f);
  endfunction

  function automatic logic model_err(input logic [7:0] slverr, input int rlast_mode);
    return (slverr != 8'h00) || (rlast_mode != 0);
  endfunction

  // AXI slave + cache-side driver for one fill. rlast_mode: 0 normal, 1 on beat 5, 2 never.
  // abort_beats > 0 stops driving once that many beats have been accepted.
  task automatic do_fill(input logic [31:0] addr, input logic [31:0] beats [8], input int ar_delay,
                         input bit gaps, input logic [7:0] slverr, input int rlast_mode,
                         input int resp_delay, input int abort_beats);
    int k, ar_wait, resp_wait, c;
    bit ar_done, ar_seen, resp_seen, gap_t, done;
    k = 0; ar_wait = 0; resp_wait = 0; c = 1;
    ar_done = 0; ar_seen = 0; resp_seen = 0; gap_t = 0; done = 0;
    obs_ar_unstable = 0; obs_rready_early = 0; obs_busy_bad = 0; obs_hold_bad = 0; obs_timeout = 0;
    obs_ar_cycle = -1; obs_resp_cycle = -1; obs_beats_at_resp = -1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    while (!done && c < 400) begin
      if (req_ready !== 1'b0) obs_busy_bad = 1;
      if (ar_done && k < 8) begin
        gap_t  = ~gap_t;
        rvalid = gaps ? gap_t : 1'b1;
        rdata  = beats[k];
        rresp  = slverr[k] ? 2'b10 : 2'b00;
        rlast  = (rlast_mode == 0) ? (k == 7) : (rlast_mode == 1) ? (k == 5) : 1'b0;
        rid    = 4'($urandom);
        if (rvalid && rready === 1'b1) begin
          k++;
          if (abort_beats > 0 && k == abort_beats) done = 1;
        end
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
      if (!ar_done) begin
        if (rready === 1'b1) obs_rready_early = 1;
        if (arvalid === 1'b1) begin
          if (!ar_seen) begin
            ar_seen = 1; obs_ar_cycle = c;
            obs_araddr = araddr; obs_arburst = arburst; obs_arlen = arlen;
            obs_arsize = arsize; obs_arid = arid;
          end else if ({araddr, arburst, arlen, arsize, arid} !==
                       {obs_araddr, obs_arburst, obs_arlen, obs_arsize, obs_arid}) begin
            obs_ar_unstable = 1;
          end
          arready = (ar_wait >= ar_delay);
          ar_wait++;
          if (arready) ar_done = 1;
        end else begin
          arready = 1'b0;
        end
      end else begin
        arready = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        if (!resp_seen) begin
          resp_seen = 1; obs_resp_cycle = c; obs_line = resp_line; obs_err = resp_err;
          obs_beats_at_resp = k;
        end else if (resp_line !== obs_line || resp_err !== obs_err) begin
          obs_hold_bad = 1;
        end
        resp_ready = (resp_wait >= resp_delay);
        resp_wait++;
        if (resp_ready) done = 1;
      end else begin
        resp_ready = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    if (!done) obs_timeout = 1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0; resp_ready = 1'b0;
    obs_req_ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    n_checks++; if ({arvalid, rready, resp_valid, resp_err} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b exp 0000", {arvalid, rready, resp_valid, resp_err}); end
    n_checks++; if (resp_line !== 256'h0) begin n_err++; $display("FAIL reset_line: got %h exp 0", resp_line); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] b [8];
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) b[i] = 32'hA0 + 32'(i);
    exp_line = model_line(32'h0000_1234, b);
    do_fill(32'h0000_1234, b, 0, 0, 8'h00, 0, 0, 0);
    n_checks++; if (obs_timeout) begin n_err++; $display("FAIL basic_timeout: got timeout exp completion"); end
    n_checks++; if (obs_araddr !== model_araddr(32'h0000_1234)) begin n_err++; $display("FAIL basic_araddr: got %h exp %h", obs_araddr, model_araddr(32'h0000_1234)); end
    n_checks++; if ({obs_arlen, obs_arsize, obs_arid} !== {8'd7, 3'd2, 4'd0}) begin n_err++; $display("FAIL basic_arfields: got len=%0d size=%0d id=%0d exp 7 2 0", obs_arlen, obs_arsize, obs_arid); end
    n_checks++; if (obs_arburst !== (WRAP_EN ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL basic_arburst: got %b exp %b", obs_arburst, WRAP_EN ? 2'b10 : 2'b01); end
    n_checks++; if (obs_ar_cycle !== 1) begin n_err++; $display("FAIL basic_ar_cycle: got %0d exp 1", obs_ar_cycle); end
    n_checks++; if (obs_resp_cycle !== 10) begin n_err++; $display("FAIL basic_resp_cycle: got %0d exp 10", obs_resp_cycle); end
    n_checks++; if (obs_line !== exp_line) begin n_err++; $display("FAIL basic_line: got %h exp %h", obs_line, exp_line); end
    n_checks++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b exp 0", obs_err); end
    n_checks++; if (obs_req_ready_after !== 1'b1 || obs_busy_bad) begin n_err++; $display("FAIL basic_req_ready: after=%b busy_bad=%0d exp 1 0", obs_req_ready_after, obs_busy_bad); end
  endtask

  task automatic test_ar_backpressure();
    logic [31:0] b [8];
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 5, 0, 8'h00, 0, 0, 0);
    n_checks++; if (obs_ar_unstable) begin n_err++; $display("FAIL bp_ar_stable: got unstable exp stable"); end
    n_checks++; if (obs_rready_early || obs_busy_bad) begin n_err++; $display("FAIL bp_ready: rready_early=%0d busy=%0d exp 0 0", obs_rready_early, obs_busy_bad); end
    n_checks++; if (obs_araddr !== model_araddr(a)) begin n_err++; $display("FAIL bp_araddr: got %h exp %h", obs_araddr, model_araddr(a)); end
    n_checks++; if (obs_resp_cycle !== 15) begin n_err++; $display("FAIL bp_resp_cycle: got %0d exp 15", obs_resp_cycle); end
    n_checks++; if (obs_line !== model_line(a, b)) begin n_err++; $display("FAIL bp_line: got %h exp %h", obs_line, model_line(a, b)); end
  endtask

  task automatic test_gaps_err();
    logic [31:0] b [8];
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 0, 1, 8'b0000_1000, 0, 0, 0);
    n_checks++; if (obs_line !== model_line(a, b)) begin n_err++; $display("FAIL gaps_line: got %h exp %h", obs_line, model_line(a, b)); end
    n_checks++; if (obs_err !== 1'b1) begin n_err++; $display("FAIL gaps_slverr: got %b exp 1", obs_err); end
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 0, 0, 8'h00, 0, 0, 0);
    n_checks++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL gaps_err_cleared: got %b exp 0", obs_err); end
  endtask

  task automatic test_rlast();
    logic [31:0] b [8];
    logic [31:0] a;
    for (int m = 1; m <= 2; m++) begin
      a = $urandom;
      for (int i = 0; i < 8; i++) b[i] = $urandom;
      do_fill(a, b, 0, 0, 8'h00, m, 0, 0);
      n_checks++; if (obs_beats_at_resp !== 8) begin n_err++; $display("FAIL rlast%0d_beats: got %0d exp 8", m, obs_beats_at_resp); end
      n_checks++; if (obs_line !== model_line(a, b)) begin n_err++; $display("FAIL rlast%0d_line: got %h exp %h", m, obs_line, model_line(a, b)); end
      n_checks++; if (obs_err !== 1'b1) begin n_err++; $display("FAIL rlast%0d_err: got %b exp 1", m, obs_err); end
    end
  endtask

  task automatic test_resp_hold();
    logic [31:0] b [8];
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 0, 0, 8'h01, 0, 4, 0);
    n_checks++; if (obs_hold_bad || obs_busy_bad) begin n_err++; $display("FAIL hold_stable: hold_bad=%0d busy=%0d exp 0 0", obs_hold_bad, obs_busy_bad); end
    n_checks++; if (obs_line !== model_line(a, b) || obs_err !== 1'b1) begin n_err++; $display("FAIL hold_data: got %h err=%b exp %h err=1", obs_line, obs_err, model_line(a, b)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b [8];
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 0, 0, 8'h02, 0, 0, 4);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_req_ready: got %b exp 1", req_ready); end
    n_checks++; if ({arvalid, rready, resp_valid, resp_err} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctrl: got %b exp 0000", {arvalid, rready, resp_valid, resp_err}); end
    n_checks++; if (resp_line !== 256'h0) begin n_err++; $display("FAIL midrst_line: got %h exp 0", resp_line); end
    rst = 1'b0;
    a = $urandom;
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    do_fill(a, b, 0, 0, 8'h00, 0, 0, 0);
    n_checks++; if (obs_line !== model_line(a, b) || obs_err !== 1'b0 || obs_resp_cycle !== 10) begin n_err++; $display("FAIL midrst_recover: got %h err=%b cyc=%0d exp %h err=0 cyc=10", obs_line, obs_err, obs_resp_cycle, model_line(a, b)); end
  endtask

  task automatic test_random();
    logic [31:0] b [8];
    logic [31:0] a;
    logic [7:0]  se;
    int          rm;
    for (int t = 0; t < 12; t++) begin
      a  = $urandom;
      for (int i = 0; i < 8; i++) b[i] = $urandom;
      se = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      rm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_fill(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), se, rm, int'($urandom_range(0, 3)), 0);
      n_checks++; if (obs_araddr !== model_araddr(a)) begin n_err++; $display("FAIL rand%0d_araddr: got %h exp %h", t, obs_araddr, model_araddr(a)); end
      n_checks++; if (obs_line !== model_line(a, b)) begin n_err++; $display("FAIL rand%0d_line: got %h exp %h", t, obs_line, model_line(a, b)); end
      n_checks++; if (obs_err !== model_err(se, rm)) begin n_err++; $display("FAIL rand%0d_err: got %b exp %b", t, obs_err, model_err(se, rm)); end
    end
  endtask

`ifdef ICACHE_REFILL_WRAP_EN
  task automatic test_wrap();
    logic [31:0] b [8];
    logic [31:0] w;
    for (int i = 0; i < 8; i++) b[i] = 32'hB0 + 32'(i);
    do_fill(32'h0000_1234, b, 0, 0, 8'h00, 0, 0, 0);
    n_checks++; if (obs_araddr !== 32'h0000_1234 || obs_arburst !== 2'b10) begin n_err++; $display("FAIL wrap_ar: got %h/%b exp 00001234/10", obs_araddr, obs_arburst); end
    for (int i = 0; i < 8; i++) begin
      w = obs_line[i*32 +: 32];
      n_checks++; if (w !== 32'hB0 + 32'((i + 3) % 8)) begin n_err++; $display("FAIL wrap_word%0d: got %h exp %h", i, w, 32'hB0 + 32'((i + 3) % 8)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_gaps_err();
    test_rlast();
    test_resp_hold();
    test_reset_mid();
`ifdef ICACHE_REFILL_WRAP_EN
    test_wrap();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
